// File: rtl/task2_pkg.sv
// -----------------------------------------------------------------------------
// task2_pkg
// Definitions shared by the ARC4 key-scheduling engine (task2) and its RAM
// (s_mem):
//   - state_t   : top FSM states. RD_I..WR_J are the six phases of one
//                 KSA iteration.
//   - KEY_LEN   : number of key bytes that are cycled through during KSA.
//   - MEM_DEPTH : number of entries in the permutation RAM "s".
// -----------------------------------------------------------------------------
package task2_pkg;

    localparam int KEY_LEN   = 3;
    localparam int MEM_DEPTH = 256;

    typedef enum logic [2:0] {
        INIT,
        RD_I,
        WAIT_I,
        CALC_J,
        WAIT_J,
        WR_I,
        WR_J,
        DONE
    } state_t;

endpackage

// File: rtl/s_mem.sv
// -----------------------------------------------------------------------------
// s_mem
// 256x8 single-port synchronous RAM. The read address is registered, so q
// holds mem[address] one cycle after that address is presented. A write to
// mem[address] happens on the clock edge where wren=1.
//
// Ports:
//   clock        in   clock, rising edge
//   address[7:0] in   read/write address
//   data[7:0]    in   write data
//   wren         in   write enable
//   q[7:0]       out  read data, from the address registered on the last edge
// -----------------------------------------------------------------------------
module s_mem
    import task2_pkg::*;
(
    input  logic       clock,
    input  logic [7:0] address,
    input  logic [7:0] data,
    input  logic       wren,
    output logic [7:0] q
);

    logic [7:0] mem [MEM_DEPTH];
    logic [7:0] r_addr;

    // NOTE: this block has no reset on purpose. A reset here would stop the
    // array from mapping onto block RAM. The contents are overwritten by INIT
    // before anything reads them.
    always_ff @(posedge clock) begin
        r_addr <= address;
        if (wren) begin
            mem[address] <= data;
        end
    end

    assign q = mem[r_addr];

endmodule

// File: rtl/task2.sv
// -----------------------------------------------------------------------------
// task2
// ARC4 key-scheduling engine. On the first clock after reset is released it
// latches a 24-bit key {14'b0, SW}. It then fills RAM "s" with the identity
// permutation (256 cycles). After that it runs the 256 KSA swap iterations,
// each of which takes 6 cycles. It then stays in DONE until the next reset.
//
// Ports:
//   CLOCK_50      in   clock
//   KEY[3:0]      in   KEY[3] is the asynchronous active-low reset; KEY[2:0] unused
//   SW[9:0]       in   key source, latched once per run
//   HEX0..HEX5    out  active-low 7-segment digits (bit 0 = a ... bit 6 = g)
//   LEDR[9:0]     out  LEDR[0] = done, LEDR[1] = busy, others 0
//
// Build option: define TASK2_HEX_KEY_EN to show the latched key on HEX5..HEX0.
// Without it, every digit is blank (7'h7F).
// -----------------------------------------------------------------------------
module task2
    import task2_pkg::*;
(
    input  logic       CLOCK_50,
    input  logic [3:0] KEY,
    input  logic [9:0] SW,
    output logic [6:0] HEX0,
    output logic [6:0] HEX1,
    output logic [6:0] HEX2,
    output logic [6:0] HEX3,
    output logic [6:0] HEX4,
    output logic [6:0] HEX5,
    output logic [9:0] LEDR
);

    logic        w_rst_n;
    logic        w_unused_keys;

    state_t      r_state;
    state_t      w_state_next;

    logic [7:0]  r_i;
    logic [7:0]  r_j;
    logic [7:0]  r_si;
    logic [23:0] r_key;
    logic [1:0]  r_kidx;        // i mod KEY_LEN, tracked incrementally
    logic        r_key_loaded;
    logic        r_busy;
    logic        r_done;

    logic [7:0]  w_q;
    logic [7:0]  w_addr;
    logic [7:0]  w_data;
    logic        w_wren;
    logic [7:0]  w_key_byte;
    logic [7:0]  w_j_new;

    assign w_rst_n       = KEY[3];
    assign w_unused_keys = &{1'b0, KEY[2:0]};

    s_mem s (
        .clock   (CLOCK_50),
        .address (w_addr),
        .data    (w_data),
        .wren    (w_wren),
        .q       (w_q)
    );

    // key[0] is the most significant byte of the latched key.
    always_comb begin
        case (r_kidx)
            2'd0:    w_key_byte = r_key[23:16];
            2'd1:    w_key_byte = r_key[15:8];
            default: w_key_byte = r_key[7:0];
        endcase
    end

    // In CALC_J the RAM output holds s[i]. All 8-bit sums wrap modulo 256.
    assign w_j_new = r_j + w_q + w_key_byte;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge CLOCK_50 or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state <= INIT;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default before the case.
        // A path that leaves one unassigned would infer a latch.
        w_state_next = r_state;
        w_addr       = r_i;
        w_data       = r_i;
        w_wren       = 1'b0;

        case (r_state)
            INIT: begin
                // The first cycle after reset only latches the key. The
                // following 256 cycles write s[i] = i.
                if (r_key_loaded) begin
                    w_wren = 1'b1;
                    if (r_i == 8'hFF) begin
                        w_state_next = RD_I;
                    end
                end
            end
            RD_I: begin
                w_state_next = WAIT_I;
            end
            WAIT_I: begin
                w_state_next = CALC_J;
            end
            CALC_J: begin
                // Present the new j directly so that s[j] is on q in WR_I.
                w_addr       = w_j_new;
                w_state_next = WAIT_J;
            end
            WAIT_J: begin
                w_addr       = r_j;
                w_state_next = WR_I;
            end
            WR_I: begin
                // q holds s[j]. When i == j this writes back the same value.
                w_data       = w_q;
                w_wren       = 1'b1;
                w_state_next = WR_J;
            end
            WR_J: begin
                w_addr       = r_j;
                w_data       = r_si;
                w_wren       = 1'b1;
                w_state_next = (r_i == 8'hFF) ? DONE : RD_I;
            end
            DONE: begin
                w_state_next = DONE;
            end
            default: begin
                w_state_next = INIT;
            end
        endcase
    end

    // ----------------------------------------------------------- datapath
    // NOTE: sequential state uses non-blocking assignments. Every register
    // then updates from values taken before the edge, whatever the order of
    // the statements.
    always_ff @(posedge CLOCK_50 or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_i          <= '0;
            r_j          <= '0;
            r_si         <= '0;
            r_key        <= '0;
            r_kidx       <= '0;
            r_key_loaded <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_busy <= (w_state_next != DONE);
            r_done <= (w_state_next == DONE);

            case (r_state)
                INIT: begin
                    if (!r_key_loaded) begin
                        r_key        <= {14'b0, SW};
                        r_key_loaded <= 1'b1;
                    end else begin
                        // r_i wraps from 255 to 0, ready for the KSA phase.
                        r_i <= r_i + 8'd1;
                        if (r_i == 8'hFF) begin
                            r_j    <= '0;
                            r_kidx <= '0;
                        end
                    end
                end
                CALC_J: begin
                    r_si <= w_q;
                    r_j  <= w_j_new;
                end
                WR_J: begin
                    r_i    <= r_i + 8'd1;
                    r_kidx <= (r_kidx == 2'(KEY_LEN - 1)) ? 2'd0 : r_kidx + 2'd1;
                end
                default: begin
                end
            endcase
        end
    end

    assign LEDR = {8'b0, r_busy, r_done};

    // ------------------------------------------------------------ display
`ifdef TASK2_HEX_KEY_EN
    function automatic logic [6:0] hex_glyph(input logic [3:0] n);
        case (n)
            4'h0:    return 7'h40;
            4'h1:    return 7'h79;
            4'h2:    return 7'h24;
            4'h3:    return 7'h30;
            4'h4:    return 7'h19;
            4'h5:    return 7'h12;
            4'h6:    return 7'h02;
            4'h7:    return 7'h78;
            4'h8:    return 7'h00;
            4'h9:    return 7'h10;
            4'hA:    return 7'h08;
            4'hB:    return 7'h03;
            4'hC:    return 7'h46;
            4'hD:    return 7'h21;
            4'hE:    return 7'h06;
            default: return 7'h0E;
        endcase
    endfunction

    assign HEX0 = hex_glyph(r_key[3:0]);
    assign HEX1 = hex_glyph(r_key[7:4]);
    assign HEX2 = hex_glyph(r_key[11:8]);
    assign HEX3 = hex_glyph(r_key[15:12]);
    assign HEX4 = hex_glyph(r_key[19:16]);
    assign HEX5 = hex_glyph(r_key[23:20]);
`else
    assign HEX0 = 7'h7F;
    assign HEX1 = 7'h7F;
    assign HEX2 = 7'h7F;
    assign HEX3 = 7'h7F;
    assign HEX4 = 7'h7F;
    assign HEX5 = 7'h7F;
`endif

endmodule

// File: tb/tb_task2.sv
// -----------------------------------------------------------------------------
// tb_task2
// Self-checking bench for task2. The reference model computes the ARC4 KSA
// directly from its definition on a plain array. A per-cycle monitor checks
// LEDR and the HEX digits against the cycle count since reset release.
// Directed runs check RAM contents at the end of INIT, after a few KSA
// iterations and at DONE.
// -----------------------------------------------------------------------------
module tb_task2;

    logic       clk = 1'b0;
    logic [3:0] key = 4'b0111;
    logic [9:0] sw  = '0;
    logic [6:0] hex0, hex1, hex2, hex3, hex4, hex5;
    logic [9:0] ledr;
    logic       rst_n;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    logic [23:0] exp_key  = '0;
    logic [7:0]  model_s [256];

    localparam logic [6:0] GLYPH [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    always #5 clk = ~clk;
    assign rst_n = key[3];

    task2 dut (
        .CLOCK_50 (clk),
        .KEY      (key),
        .SW       (sw),
        .HEX0     (hex0),
        .HEX1     (hex1),
        .HEX2     (hex2),
        .HEX3     (hex3),
        .HEX4     (hex4),
        .HEX5     (hex5),
        .LEDR     (ledr)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t cyc=%0d)", name, act, exp, $time, cyc);
    endtask

    // Number of rising edges since the most recent reset release.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // ARC4 KSA applied for n_iter iterations. n_iter = 0 gives the identity.
    function automatic void build_model(input logic [23:0] k, input int n_iter);
        int         j;
        logic [7:0] t;
        logic [7:0] kb [3];
        kb[0] = k[23:16];
        kb[1] = k[15:8];
        kb[2] = k[7:0];
        for (int i = 0; i < 256; i++) model_s[i] = 8'(i);
        j = 0;
        for (int i = 0; i < n_iter; i++) begin
            j          = (j + int'(model_s[i]) + int'(kb[i % 3])) % 256;
            t          = model_s[i];
            model_s[i] = model_s[j];
            model_s[j] = t;
        end
    endfunction

    task automatic check_mem(input string name, input logic [23:0] k, input int n_iter);
        int bad;
        bad = 0;
        build_model(k, n_iter);
        for (int i = 0; i < 256; i++) begin
            if (dut.s.mem[i] !== model_s[i]) begin
                if (bad == 0) $display("  %s: first difference at s[%0d]: %0h vs %0h",
                                       name, i, dut.s.mem[i], model_s[i]);
                bad++;
            end
        end
        check(name, 64'(bad), 64'd0);
    endtask

    // Per-cycle monitor for status and display outputs.
    logic [9:0]  mon_ledr;
    logic [23:0] mon_key;
    always @(negedge clk) begin
        if (!rst_n || cyc == 0) mon_ledr = 10'b00;
        else if (cyc < 1793)    mon_ledr = 10'b10;
        else                    mon_ledr = 10'b01;
        check("ledr", 64'(ledr), 64'(mon_ledr));
        mon_key = (!rst_n || cyc == 0) ? 24'd0 : exp_key;
`ifdef TASK2_HEX_KEY_EN
        check("hex", 64'({hex5, hex4, hex3, hex2, hex1, hex0}),
              64'({GLYPH[mon_key[23:20]], GLYPH[mon_key[19:16]], GLYPH[mon_key[15:12]],
                   GLYPH[mon_key[11:8]], GLYPH[mon_key[7:4]], GLYPH[mon_key[3:0]]}));
`else
        check("hex", 64'({hex5, hex4, hex3, hex2, hex1, hex0}), 64'({6{7'h7F}}));
`endif
    end

    task automatic do_reset(input logic [9:0] sw_val);
        @(posedge clk);
        #2 key[3] = 1'b0;
        #1 check("async_reset_ledr", 64'(ledr[1:0]), 64'd0);
        sw = sw_val;
        @(posedge clk);
        #2 key[3] = 1'b1;
        exp_key = {14'b0, sw_val};
    endtask

    task automatic wait_cyc(input int target, input string name);
        for (int t = 0; t < 2000 && cyc < target; t++) @(negedge clk);
        if (cyc < target) check({"timeout_", name}, 64'(cyc), 64'(target));
    endtask

    task automatic run_to_done(input string name);
        for (int t = 0; t < 1900 && ledr[0] !== 1'b1; t++) @(negedge clk);
        check({name, "_done"}, 64'(ledr[0]), 64'd1);
        check({name, "_latency"}, 64'(cyc), 64'd1793);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Run A: key 0x0000D6.
        do_reset(10'h0D6);
        wait_cyc(1, "a_latch");
`ifdef TASK2_HEX_KEY_EN
        check("a_hex0_6", 64'(hex0), 64'h02);
        check("a_hex1_d", 64'(hex1), 64'h21);
        check("a_hex5_2", 64'({hex5, hex4, hex3, hex2}), 64'({4{7'h40}}));
`else
        check("a_hex_blank", 64'({hex5, hex4, hex3, hex2, hex1, hex0}), 64'({6{7'h7F}}));
`endif
        wait_cyc(257, "a_init");
        check_mem("a_init_identity", 24'h0000D6, 0);
        wait_cyc(275, "a_iter2");
        check("a_s2_lit", 64'(dut.s.mem[2]), 64'hD9);
        check("a_sD9_lit", 64'(dut.s.mem[8'hD9]), 64'h02);
        check_mem("a_iter2_model", 24'h0000D6, 3);
        run_to_done("a");
        check_mem("a_final", 24'h0000D6, 256);

        // Run B: key 0.
        do_reset(10'h000);
        wait_cyc(281, "b_iter3");
        check("b_s3_lit", 64'(dut.s.mem[3]), 64'h05);
        check("b_s5_lit", 64'(dut.s.mem[5]), 64'h02);
        check_mem("b_iter3_model", 24'h000000, 4);
        run_to_done("b");
        check_mem("b_final", 24'h000000, 256);

        // Run C: SW changes while in DONE must have no effect until reset.
        sw = 10'h33C;
        repeat (20) @(negedge clk);
        check("c_hold_done", 64'(ledr[1:0]), 64'b01);
        check_mem("c_done_unchanged", 24'h000000, 256);
        do_reset(10'h33C);
        wait_cyc(1, "c_release");
        check("c_busy_after_release", 64'(ledr[1:0]), 64'b10);
        run_to_done("c");
        check_mem("c_final", 24'h00033C, 256);

        // Run D: abort mid-KSA, restart with a different key.
        do_reset(10'h2A5);
        wait_cyc(500, "d_mid");
        do_reset(10'h1F0);
        wait_cyc(257, "d_init");
        check_mem("d_reinit_identity", 24'h0001F0, 0);
        run_to_done("d");
        check_mem("d_final", 24'h0001F0, 256);

        // Run E: SW toggles during the run are ignored.
        do_reset(10'h155);
        wait_cyc(300, "e_t1");
        sw = 10'h2AA;
        wait_cyc(900, "e_t2");
        sw = 10'h3FF;
        wait_cyc(1500, "e_t3");
        sw = 10'h001;
        run_to_done("e");
        check_mem("e_final", 24'h000155, 256);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/task2.md
TASK2 -- requirements
Module: task2

Interface
REQ-001 CLOCK_50  input  1  sole clock; all state on its rising edge.
REQ-002 KEY  input  4  KEY[3] is the reset, asynchronous and active-low; KEY[2:0] unused.
REQ-003 SW  input  10  key source; key[23:0] = {14'b0, SW[9:0]}.
REQ-004 HEX0..HEX5  output  7 each  active-low seven-segment digits, segment bit 0 = a ... bit 6 = g.
REQ-005 LEDR  output  10  LEDR[0] = done, LEDR[1] = busy, LEDR[9:2] = 0.

Function
REQ-006 Internal state SHALL include a 256x8 single-port synchronous RAM "s":
- registered address;
- read data valid one cycle after the address is presented;
- write takes effect on the clock edge when wren=1.
REQ-007 The key SHALL be latched from SW on the first clock after reset release; later SW changes SHALL be ignored until the next reset.
REQ-008 The top FSM SHALL run the states INIT -> KSA -> DONE and hold in DONE until reset.
REQ-009 INIT SHALL write s[i]=i for i=0..255, one write per cycle (256 cycles), then enter KSA with i=0, j=0.
REQ-010 KSA SHALL, for i=0..255, compute j=(j+s[i]+key[i mod 3]) mod 256, then swap s[i] and s[j].
- key[0] = key[23:16], key[1] = key[15:8], key[2] = key[7:0].
REQ-011 Each KSA iteration SHALL take exactly 6 cycles, in this order:
- RD_I: address i.
- WAIT_I.
- CALC_J: latch si=q; compute new j; address j.
- WAIT_J.
- WR_I: write s[i]=sj.
- WR_J: write s[j]=si.
REQ-012 When i=j, the swap SHALL leave s[i] unchanged.
REQ-013 All arithmetic on i, j and key bytes SHALL be 8-bit and wrap modulo 256.
REQ-014 After the iteration with i=255, the FSM SHALL enter DONE.
- Total time from reset release to done=1 is 1+256+1536 cycles (<=1800).
REQ-015 busy SHALL be 1 in INIT and KSA and 0 in DONE.
- done SHALL be 1 only in DONE.
REQ-016 In DONE the RAM SHALL not be written; its contents SHALL be the ARC4 KSA permutation for the latched key.

Reset
REQ-017 KEY[3]=0 SHALL asynchronously reset:
- the FSM to INIT;
- i, j and the key register to 0;
- done and busy to 0.
REQ-018 Asserting reset mid-INIT or mid-KSA SHALL abort the run.
- On release, a full INIT+KSA SHALL restart using the newly latched SW.
- No stale j or key value from the aborted run SHALL be used.
REQ-019 RAM contents SHALL not be cleared by reset; INIT overwrites them.

Configuration
REQ-020 With macro TASK2_HEX_KEY_EN defined:
- HEX5..HEX0 SHALL show key[23:0] as six hex digits, HEX0 = key[3:0].
- Glyphs 0-9 and A-F are standard; b and d are lowercase.
REQ-021 Without TASK2_HEX_KEY_EN, all HEX outputs SHALL be 7'h7F (blank) and no decoder logic is compiled.

Structure
REQ-022 A shared package task2_pkg SHALL hold:
- the FSM state enum (INIT, RD_I, WAIT_I, CALC_J, WAIT_J, WR_I, WR_J, DONE);
- KEY_LEN=3 and MEM_DEPTH=256.
REQ-023 One sub-module, s_mem (256x8 single-port RAM), SHALL be instantiated as "s".
- Ports: clock, address[7:0], data[7:0], wren, q[7:0].
- Array named mem, readable hierarchically by benches.
REQ-024 Init and KSA sequencing SHALL live in task2 itself.

Verification
REQ-025 Reset pulse, SW=10'h0D6 -> INIT complete at cycle 257 with s[i]=i for all i; done=1 by cycle 1800; s equals the golden KSA for key 0x0000D6; e.g. after i=2, s[2]=0xD9 and s[0xD9]=0x02.
REQ-026 SW=0, run to done -> s equals the golden KSA for key 0x000000; e.g. after i=3, s[3]=0x05 and s[5]=0x02.
REQ-027 Change SW to 10'h33C while done=1, then reset -> busy=1, done=0 immediately; new run completes with s equal to the golden KSA for key 0x00033C.
REQ-028 Reset asserted 500 cycles after release (mid-KSA), then released -> the run restarts from INIT; final s matches the golden model with no corruption.
REQ-029 Toggle SW during KSA -> final s still matches the key latched at reset release.
REQ-030 With TASK2_HEX_KEY_EN and SW=10'h0D6 -> HEX1/HEX0 show "d"/"6", HEX5..HEX2 show "0"; without the macro -> all HEX = 7'h7F.
